multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control sequencer for the multi-cycle MIPS datapath.
- Decodes the 6-bit opcode and steps the datapath through fetch, decode, execute, memory and writeback phases.
- Drives the 2-bit ALUOp consumed by the ALU control decoder, plus the mux selects and write strobes for PC, IR, register file and memory.
- Waits on a memory-ready handshake for every memory access.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_Opcode  input  6  IR[31:26], valid from DECODE onward
- i_mem_ready  input  1  memory completed the current read/write this cycle
- o_MemRead  output  1  memory read request
- o_MemWrite  output  1  memory write request
- o_IorD  output  1  0 = PC address, 1 = ALUOut address
- o_IRWrite  output  1  load instruction register
- o_PCWrite  output  1  unconditional PC load
- o_Branch  output  1  PC load qualified by ALU zero
- o_PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- o_ALUSrcA  output  1  0 = PC, 1 = register A
- o_ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
- o_ALUOp  output  2  00 = add, 01 = subtract, 10 = R-type funct decode
- o_RegDst  output  1  0 = rt, 1 = rd
- o_MemtoReg  output  1  0 = ALUOut, 1 = MDR
- o_RegWrite  output  1  register file write
- o_illegal  output  1  one-cycle pulse on unrecognised opcode
- o_state  output  4  current state encoding, for debug and bench

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are a combinational decode of the state, except the memory-gated strobes noted below.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Reset:
  - i_rst_n low forces state to FETCH immediately, with no clock needed.
  - While in reset, every write strobe is forced to 0: o_IRWrite, o_PCWrite, o_Branch, o_RegWrite, o_MemWrite, o_MemRead and o_illegal.
  - All other outputs show their FETCH values.
  - Reset asserted mid-instruction abandons that instruction; no partial writeback occurs.
- Unlisted outputs are 0 in each state below.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite equal i_mem_ready.
  - Stays in FETCH while i_mem_ready=0; goes to DECODE when i_mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target computed into ALUOut).
  - Next state by opcode: LW or SW goes to MEMADR, RTYPE to EXEC, BEQ to BRANCH, J to JUMP, ADDI to ADDIEX.
  - Any other opcode goes to FETCH with o_illegal=1 for this one cycle.
- MEMADR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Goes to MEMRD for LW, MEMWR for SW.
- MEMRD:
  - Outputs: MemRead=1, IorD=1.
  - Holds until i_mem_ready=1, then goes to MEMWB.
- MEMWB:
  - Outputs: RegDst=0, MemtoReg=1, RegWrite=1.
  - Goes to FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1.
  - Holds until i_mem_ready=1, then goes to FETCH.
- EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Goes to ALUWB.
- ALUWB:
  - Outputs: RegDst=1, MemtoReg=0, RegWrite=1.
  - Goes to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - Goes to FETCH.
- JUMP:
  - Outputs: PCSrc=10, PCWrite=1.
  - Goes to FETCH.
- ADDIEX:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Goes to ADDIWB.
- ADDIWB:
  - Outputs: RegDst=0, MemtoReg=0, RegWrite=1.
  - Goes to FETCH.
- Undefined state values 12–15 go to FETCH on the next edge; all strobes are 0 while in them.
- Cycle counts with zero memory wait, fetch included: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each cycle of i_mem_ready=0 in a memory state adds exactly one cycle.
- i_Opcode is sampled only in DECODE and MEMADR. Changes in other states are ignored.
- o_MemRead and o_MemWrite are never high together. RegWrite, PCWrite and IRWrite never assert outside the states listed above.

Test Plan:
- Reset mid-instruction:
  - Stimulus: hold i_rst_n=0 asynchronously during EXEC.
  - Required: o_state=0 before the next clock edge; RegWrite and IRWrite=0; after release, FETCH waits on i_mem_ready.
- LW, i_Opcode=6'b100011, i_mem_ready=1 always:
  - Required state sequence: 0,1,2,3,4,0.
  - Required: o_ALUOp=00 in MEMADR; MemtoReg=1 and RegWrite=1 only in state 4.
- R-type, i_Opcode=6'b000000:
  - Required state sequence: 0,1,6,7,0.
  - Required: o_ALUOp=10 in state 6; RegDst=1 and RegWrite=1 in state 7.
- BEQ with memory stall, i_Opcode=6'b000100, i_mem_ready=0 for 3 FETCH cycles:
  - Required: FETCH held 4 cycles with IRWrite=0 until ready.
  - Required: in BRANCH, ALUOp=01, Branch=1, PCSrc=01.
- SW, i_Opcode=6'b101011, i_mem_ready low for 2 cycles in MEMWR:
  - Required: MemWrite=1 for 3 cycles, IorD=1, then FETCH.
  - Required: RegWrite=0 throughout.
- Illegal opcode 6'b111111, plus J 6'b000010:
  - Illegal required: o_illegal pulses 1 cycle in DECODE, then FETCH, with no RegWrite.
  - J required: state sequence 0,1,9,0 with PCWrite=1 and PCSrc=10 in state 9.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multi-cycle MIPS datapath.
//
// The FSM steps each instruction through fetch, decode, execute, memory and
// writeback phases. It decodes the 6-bit opcode and drives the datapath mux
// selects, the ALUOp field for the ALU control decoder, and the write strobes.
//
// State table (state | meaning):
//   FETCH  (0)  | read instruction at PC, PC+4 -> PC, waits on memory
//   DECODE (1)  | register read, branch target -> ALUOut, dispatch on opcode
//   MEMADR (2)  | effective address A + signext(imm) for LW/SW
//   MEMRD  (3)  | data read at ALUOut, waits on memory
//   MEMWB  (4)  | MDR -> rt
//   MEMWR  (5)  | data write at ALUOut, waits on memory
//   EXEC   (6)  | R-type ALU operation A op B
//   ALUWB  (7)  | ALUOut -> rd
//   BRANCH (8)  | A - B, PC <= ALUOut when zero
//   JUMP   (9)  | PC <= jump target
//   ADDIEX (10) | A + signext(imm)
//   ADDIWB (11) | ALUOut -> rt
//   12..15      | unused; all strobes low, return to FETCH
//
// Ports:
//   i_clk, i_rst_n    rising-edge clock, asynchronous active-low reset
//   i_Opcode          IR[31:26], sampled only in DECODE and MEMADR
//   i_mem_ready       memory completed the current access this cycle
//   o_MemRead/o_MemWrite/o_IorD        memory request and address select
//   o_IRWrite/o_PCWrite/o_Branch/o_PCSrc  IR and PC update controls
//   o_ALUSrcA/o_ALUSrcB/o_ALUOp       ALU operand selects and op class
//   o_RegDst/o_MemtoReg/o_RegWrite    register file write controls
//   o_illegal         one-cycle pulse in DECODE on an unrecognised opcode
//   o_state           current state encoding

module multicycle_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_Opcode,
    input  logic       i_mem_ready,
    output logic       o_MemRead,
    output logic       o_MemWrite,
    output logic       o_IorD,
    output logic       o_IRWrite,
    output logic       o_PCWrite,
    output logic       o_Branch,
    output logic [1:0] o_PCSrc,
    output logic       o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ALUOp,
    output logic       o_RegDst,
    output logic       o_MemtoReg,
    output logic       o_RegWrite,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    // Ungated strobes from the state decode; reset gating is applied below.
    logic mem_read;
    logic mem_write;
    logic ir_write;
    logic pc_write;
    logic branch;
    logic reg_write;
    logic illegal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        o_IorD     = 1'b0;
        o_PCSrc    = 2'b00;
        o_ALUSrcA  = 1'b0;
        o_ALUSrcB  = 2'b00;
        o_ALUOp    = 2'b00;
        o_RegDst   = 1'b0;
        o_MemtoReg = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                o_ALUSrcB = 2'b01;
                // IR and PC only load on the cycle the instruction word arrives.
                ir_write  = i_mem_ready;
                pc_write  = i_mem_ready;
                state_d   = i_mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                o_ALUSrcB = 2'b11;
                case (i_Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                o_ALUSrcA = 1'b1;
                o_ALUSrcB = 2'b10;
                // Only LW/SW reach here; anything else is a corrupted opcode
                // and the instruction is dropped back to fetch.
                if (i_Opcode == OP_LW) begin
                    state_d = MEMRD;
                end else if (i_Opcode == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD: begin
                mem_read = 1'b1;
                o_IorD   = 1'b1;
                state_d  = i_mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                o_MemtoReg = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                o_IorD    = 1'b1;
                state_d   = i_mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                o_ALUSrcA = 1'b1;
                o_ALUOp   = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                o_RegDst  = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                o_ALUSrcA = 1'b1;
                o_ALUOp   = 2'b01;
                o_PCSrc   = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            JUMP: begin
                o_PCSrc  = 2'b10;
                pc_write = 1'b1;
                state_d  = FETCH;
            end
            ADDIEX: begin
                o_ALUSrcA = 1'b1;
                o_ALUSrcB = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // The state register already shows FETCH during reset, but FETCH itself
    // asserts MemRead and (with ready high) IRWrite/PCWrite, so every strobe
    // is also masked by the reset level to keep the datapath quiet.
    assign o_MemRead  = mem_read  & i_rst_n;
    assign o_MemWrite = mem_write & i_rst_n;
    assign o_IRWrite  = ir_write  & i_rst_n;
    assign o_PCWrite  = pc_write  & i_rst_n;
    assign o_Branch   = branch    & i_rst_n;
    assign o_RegWrite = reg_write & i_rst_n;
    assign o_illegal  = illegal   & i_rst_n;
    assign o_state    = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks reset, R-type, LW, BEQ
// with fetch stall, SW with write stall, illegal opcode, J and ADDI through
// the controller and checks state and control outputs against hand values.

module tb_multicycle_control_fsm;

    logic       i_clk;
    logic       i_rst_n;
    logic [5:0] i_Opcode;
    logic       i_mem_ready;
    logic       o_MemRead;
    logic       o_MemWrite;
    logic       o_IorD;
    logic       o_IRWrite;
    logic       o_PCWrite;
    logic       o_Branch;
    logic [1:0] o_PCSrc;
    logic       o_ALUSrcA;
    logic [1:0] o_ALUSrcB;
    logic [1:0] o_ALUOp;
    logic       o_RegDst;
    logic       o_MemtoReg;
    logic       o_RegWrite;
    logic       o_illegal;
    logic [3:0] o_state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_fsm dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_Opcode    (i_Opcode),
        .i_mem_ready (i_mem_ready),
        .o_MemRead   (o_MemRead),
        .o_MemWrite  (o_MemWrite),
        .o_IorD      (o_IorD),
        .o_IRWrite   (o_IRWrite),
        .o_PCWrite   (o_PCWrite),
        .o_Branch    (o_Branch),
        .o_PCSrc     (o_PCSrc),
        .o_ALUSrcA   (o_ALUSrcA),
        .o_ALUSrcB   (o_ALUSrcB),
        .o_ALUOp     (o_ALUOp),
        .o_RegDst    (o_RegDst),
        .o_MemtoReg  (o_MemtoReg),
        .o_RegWrite  (o_RegWrite),
        .o_illegal   (o_illegal),
        .o_state     (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge so registered state has settled.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        i_rst_n     = 1'b0;
        i_mem_ready = 1'b1;
        i_Opcode    = 6'b000000;
        #2;
        chk("rst_state",    {4'd0, o_state}, 8'd0);
        chk("rst_memread",  {7'd0, o_MemRead}, 8'd0);
        chk("rst_irwrite",  {7'd0, o_IRWrite}, 8'd0);
        chk("rst_pcwrite",  {7'd0, o_PCWrite}, 8'd0);
        chk("rst_alusrcb",  {6'd0, o_ALUSrcB}, 8'd1);

        @(negedge i_clk);
        i_rst_n     = 1'b1;
        i_mem_ready = 1'b0;
        settle();
        chk("fetch_wait_state",   {4'd0, o_state}, 8'd0);
        chk("fetch_wait_memread", {7'd0, o_MemRead}, 8'd1);
        chk("fetch_wait_irwrite", {7'd0, o_IRWrite}, 8'd0);
        tick();
        chk("fetch_hold_state",   {4'd0, o_state}, 8'd0);

        // ---------------- R-type interrupted by reset in EXEC ----------------
        i_mem_ready = 1'b1;
        i_Opcode    = 6'b000000;
        settle();
        chk("rt_fetch_irwrite", {7'd0, o_IRWrite}, 8'd1);
        chk("rt_fetch_pcwrite", {7'd0, o_PCWrite}, 8'd1);
        tick();
        chk("rt_decode_state",  {4'd0, o_state}, 8'd1);
        tick();
        chk("rt_exec_state",    {4'd0, o_state}, 8'd6);
        chk("rt_exec_aluop",    {6'd0, o_ALUOp}, 8'd2);
        i_rst_n = 1'b0;
        settle();
        chk("midrst_state",     {4'd0, o_state}, 8'd0);
        chk("midrst_regwrite",  {7'd0, o_RegWrite}, 8'd0);
        chk("midrst_irwrite",   {7'd0, o_IRWrite}, 8'd0);
        @(negedge i_clk);
        i_rst_n     = 1'b1;
        i_mem_ready = 1'b0;
        tick();
        chk("postrst_state",    {4'd0, o_state}, 8'd0);
        chk("postrst_irwrite",  {7'd0, o_IRWrite}, 8'd0);

        // ---------------- full R-type ----------------
        i_mem_ready = 1'b1;
        settle();
        chk("rt2_fetch_irwrite", {7'd0, o_IRWrite}, 8'd1);
        tick();
        chk("rt2_decode_state",  {4'd0, o_state}, 8'd1);
        tick();
        chk("rt2_exec_state",    {4'd0, o_state}, 8'd6);
        chk("rt2_exec_srca",     {7'd0, o_ALUSrcA}, 8'd1);
        chk("rt2_exec_srcb",     {6'd0, o_ALUSrcB}, 8'd0);
        chk("rt2_exec_regwrite", {7'd0, o_RegWrite}, 8'd0);
        tick();
        chk("rt2_alwb_state",    {4'd0, o_state}, 8'd7);
        chk("rt2_alwb_regdst",   {7'd0, o_RegDst}, 8'd1);
        chk("rt2_alwb_regwrite", {7'd0, o_RegWrite}, 8'd1);
        chk("rt2_alwb_memtoreg", {7'd0, o_MemtoReg}, 8'd0);
        tick();
        chk("rt2_end_state",     {4'd0, o_state}, 8'd0);

        // ---------------- LW, no wait ----------------
        i_Opcode = 6'b100011;
        tick();
        chk("lw_decode_state",   {4'd0, o_state}, 8'd1);
        chk("lw_decode_srcb",    {6'd0, o_ALUSrcB}, 8'd3);
        chk("lw_decode_regwrite",{7'd0, o_RegWrite}, 8'd0);
        tick();
        chk("lw_memadr_state",   {4'd0, o_state}, 8'd2);
        chk("lw_memadr_aluop",   {6'd0, o_ALUOp}, 8'd0);
        chk("lw_memadr_srcb",    {6'd0, o_ALUSrcB}, 8'd2);
        tick();
        chk("lw_memrd_state",    {4'd0, o_state}, 8'd3);
        chk("lw_memrd_memread",  {7'd0, o_MemRead}, 8'd1);
        chk("lw_memrd_iord",     {7'd0, o_IorD}, 8'd1);
        chk("lw_memrd_regwrite", {7'd0, o_RegWrite}, 8'd0);
        tick();
        chk("lw_memwb_state",    {4'd0, o_state}, 8'd4);
        chk("lw_memwb_memtoreg", {7'd0, o_MemtoReg}, 8'd1);
        chk("lw_memwb_regwrite", {7'd0, o_RegWrite}, 8'd1);
        chk("lw_memwb_regdst",   {7'd0, o_RegDst}, 8'd0);
        tick();
        chk("lw_end_state",      {4'd0, o_state}, 8'd0);
        chk("lw_end_memtoreg",   {7'd0, o_MemtoReg}, 8'd0);

        // ---------------- BEQ with 3-cycle fetch stall ----------------
        i_Opcode    = 6'b000100;
        i_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("beq_stall_state",   {4'd0, o_state}, 8'd0);
            chk("beq_stall_irwrite", {7'd0, o_IRWrite}, 8'd0);
            tick();
        end
        i_mem_ready = 1'b1;
        settle();
        chk("beq_ready_state",   {4'd0, o_state}, 8'd0);
        chk("beq_ready_irwrite", {7'd0, o_IRWrite}, 8'd1);
        tick();
        chk("beq_decode_state",  {4'd0, o_state}, 8'd1);
        tick();
        chk("beq_branch_state",  {4'd0, o_state}, 8'd8);
        chk("beq_branch_aluop",  {6'd0, o_ALUOp}, 8'd1);
        chk("beq_branch_branch", {7'd0, o_Branch}, 8'd1);
        chk("beq_branch_pcsrc",  {6'd0, o_PCSrc}, 8'd1);
        chk("beq_branch_pcwrite",{7'd0, o_PCWrite}, 8'd0);
        tick();
        chk("beq_end_state",     {4'd0, o_state}, 8'd0);
        chk("beq_end_branch",    {7'd0, o_Branch}, 8'd0);

        // ---------------- SW with 2-cycle write stall ----------------
        i_Opcode = 6'b101011;
        tick();
        chk("sw_decode_regwrite", {7'd0, o_RegWrite}, 8'd0);
        tick();
        chk("sw_memadr_state",    {4'd0, o_state}, 8'd2);
        tick();
        i_mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("sw_stall_state",    {4'd0, o_state}, 8'd5);
            chk("sw_stall_memwrite", {7'd0, o_MemWrite}, 8'd1);
            chk("sw_stall_memread",  {7'd0, o_MemRead}, 8'd0);
            chk("sw_stall_iord",     {7'd0, o_IorD}, 8'd1);
            chk("sw_stall_regwrite", {7'd0, o_RegWrite}, 8'd0);
            tick();
        end
        i_mem_ready = 1'b1;
        settle();
        chk("sw_ready_state",    {4'd0, o_state}, 8'd5);
        chk("sw_ready_memwrite", {7'd0, o_MemWrite}, 8'd1);
        tick();
        chk("sw_end_state",      {4'd0, o_state}, 8'd0);
        chk("sw_end_memwrite",   {7'd0, o_MemWrite}, 8'd0);

        // ---------------- illegal opcode ----------------
        i_Opcode = 6'b111111;
        settle();
        chk("ill_fetch_illegal",  {7'd0, o_illegal}, 8'd0);
        tick();
        chk("ill_decode_state",   {4'd0, o_state}, 8'd1);
        chk("ill_decode_illegal", {7'd0, o_illegal}, 8'd1);
        chk("ill_decode_regwrite",{7'd0, o_RegWrite}, 8'd0);
        tick();
        chk("ill_end_state",      {4'd0, o_state}, 8'd0);
        chk("ill_end_illegal",    {7'd0, o_illegal}, 8'd0);

        // ---------------- J ----------------
        i_Opcode = 6'b000010;
        tick();
        chk("j_decode_state",  {4'd0, o_state}, 8'd1);
        chk("j_decode_illegal",{7'd0, o_illegal}, 8'd0);
        tick();
        chk("j_jump_state",    {4'd0, o_state}, 8'd9);
        chk("j_jump_pcwrite",  {7'd0, o_PCWrite}, 8'd1);
        chk("j_jump_pcsrc",    {6'd0, o_PCSrc}, 8'd2);
        chk("j_jump_regwrite", {7'd0, o_RegWrite}, 8'd0);
        tick();
        chk("j_end_state",     {4'd0, o_state}, 8'd0);

        // ---------------- ADDI ----------------
        i_Opcode = 6'b001000;
        tick();
        tick();
        chk("addi_ex_state",    {4'd0, o_state}, 8'd10);
        chk("addi_ex_srcb",     {6'd0, o_ALUSrcB}, 8'd2);
        chk("addi_ex_srca",     {7'd0, o_ALUSrcA}, 8'd1);
        tick();
        chk("addi_wb_state",    {4'd0, o_state}, 8'd11);
        chk("addi_wb_regwrite", {7'd0, o_RegWrite}, 8'd1);
        chk("addi_wb_regdst",   {7'd0, o_RegDst}, 8'd0);
        chk("addi_wb_memtoreg", {7'd0, o_MemtoReg}, 8'd0);
        tick();
        chk("addi_end_state",   {4'd0, o_state}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
